// File: rtl/gpio_pio_pkg.sv
// Shared definitions for the Avalon-MM GPIO PIO: register word offsets and
// edge-capture mode encodings.
package gpio_pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5,
    ADDR_OUTRB   = 3'd6,
    ADDR_RSVD    = 3'd7
  } gpio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int BUS_W = 32;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain plus previous-sample register and per-bit edge
// event generation for the GPIO pad inputs.
module gpio_sync_edge
  import gpio_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] in_sync_o,
  output logic [WIDTH-1:0] event_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Both the chain and prev_q clear to zero so reset release never fakes an edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync_o = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign event_o = ~in_sync_o & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign event_o = in_sync_o ^ prev_q;
    end else begin : g_rise
      assign event_o = in_sync_o & ~prev_q;
    end
  endgenerate

endmodule

// File: rtl/avalon_gpio_pio.sv
// Parametrised GPIO peripheral on the lightweight Avalon-MM bus: data/direction
// registers, atomic set/clear, sticky edge capture and a masked level interrupt.
module avalon_gpio_pio
  import gpio_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  gpio_addr_e       addr_e;
  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_val;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             irq_q, irq_d;

  assign addr_e = gpio_addr_e'(address);
  assign wr_en  = chipselect & ~write_n;
  assign wd     = writedata[WIDTH-1:0];

  generate
    if (WIDTH < BUS_W) begin : g_wd_hi
      logic unused_wd_hi;
      assign unused_wd_hi = ^writedata[BUS_W-1:WIDTH];
    end
  endgenerate

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .pin_i     (in_port),
    .in_sync_o (in_sync),
    .event_o   (edge_evt)
  );

  // A fresh event outranks a write-1-clear of the same bit in the same cycle.
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en) begin
      case (addr_e)
        ADDR_DATA:    data_d = wd;
        ADDR_DIR:     dir_d  = wd;
        ADDR_IRQMASK: mask_d = wd;
        ADDR_EDGECAP: clr    = wd;
        ADDR_OUTSET:  data_d = data_q | wd;
        ADDR_OUTCLR:  data_d = data_q & ~wd;
        default:      ;
      endcase
    end
    cap_d = edge_evt | (cap_q & ~clr);
    irq_d = |(cap_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_OUT;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
    end
  end

  // DATA reads back driven value on outputs and the synchronised pad on inputs.
  always_comb begin
    rd_val = '0;
    case (addr_e)
      ADDR_DATA:    rd_val = (dir_q & data_q) | (~dir_q & in_sync);
      ADDR_DIR:     rd_val = dir_q;
      ADDR_IRQMASK: rd_val = mask_q;
      ADDR_EDGECAP: rd_val = cap_q;
      ADDR_OUTRB:   rd_val = data_q;
      default:      rd_val = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

  assign out_port = data_q;
  assign oe_port  = dir_q;
  assign irq      = irq_q;

  a_idle_bus_holds_regs : assert property (
    @(posedge clk) disable iff (!reset_n)
    !chipselect |=> (data_q == $past(data_q)) && (dir_q == $past(dir_q)) &&
                    (mask_q == $past(mask_q))
  );

  a_read_not_truncated : assert property (
    @(posedge clk) disable iff (!reset_n)
    readdata[WIDTH-1:0] == rd_val
  );

  generate
    if (WIDTH < BUS_W) begin : g_upper_zero
      a_read_upper_zero : assert property (
        @(posedge clk) readdata[BUS_W-1:WIDTH] == '0
      );
    end
  endgenerate

endmodule

// File: tb/tb_avalon_gpio_pio.sv
// Scoreboard bench for avalon_gpio_pio: three instances (rise/fall/any edge,
// 8- and 32-bit) share one bus and are compared against a register-map model.
module tb_avalon_gpio_pio;

  typedef struct packed {
    logic        chkRd;
    logic [2:0]  irq;
    logic [95:0] rd;
    logic [95:0] out;
    logic [95:0] oe;
  } expT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic        write_n;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] pins;

  logic [31:0] rdP [3];
  logic        irqP [3];
  logic [7:0]  out0, oe0, out1, oe1;
  logic [31:0] out2, oe2;
  logic [31:0] outP [3];
  logic [31:0] oeP [3];

  logic [31:0] mData [3];
  logic [31:0] mDir [3];
  logic [31:0] mMask [3];
  logic [31:0] mCap [3];
  logic        mIrq [3];
  logic [31:0] hist [3][4];

  expT expQ [$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always #5 clk = ~clk;

  avalon_gpio_pio #(
    .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'hFF), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdP[0]),
    .in_port(pins[7:0]), .out_port(out0), .oe_port(oe0), .irq(irqP[0])
  );

  avalon_gpio_pio #(
    .WIDTH(8), .RESET_OUT(8'h00), .RESET_DIR(8'h00), .EDGE_TYPE(1), .SYNC_STAGES(3)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdP[1]),
    .in_port(pins[7:0]), .out_port(out1), .oe_port(oe1), .irq(irqP[1])
  );

  avalon_gpio_pio #(
    .WIDTH(32), .RESET_OUT(32'h3C00_00F1), .RESET_DIR(32'h0000_FF00), .EDGE_TYPE(2),
    .SYNC_STAGES(2)
  ) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdP[2]),
    .in_port(pins), .out_port(out2), .oe_port(oe2), .irq(irqP[2])
  );

  assign outP[0] = {24'h0, out0};
  assign oeP[0]  = {24'h0, oe0};
  assign outP[1] = {24'h0, out1};
  assign oeP[1]  = {24'h0, oe1};
  assign outP[2] = out2;
  assign oeP[2]  = oe2;

  function automatic logic [31:0] wmaskOf(int i);
    return (i == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic int syncOf(int i);
    return (i == 1) ? 3 : 2;
  endfunction

  function automatic logic [31:0] rstOutOf(int i);
    case (i)
      0:       return 32'h0000_00A5;
      1:       return 32'h0000_0000;
      default: return 32'h3C00_00F1;
    endcase
  endfunction

  function automatic logic [31:0] rstDirOf(int i);
    case (i)
      0:       return 32'h0000_00FF;
      1:       return 32'h0000_0000;
      default: return 32'h0000_FF00;
    endcase
  endfunction

  // The pad value seen by software is the one sampled syncOf(i) edges ago;
  // the value one edge older is what the edge detector compares against.
  function automatic logic [31:0] eventsOf(int i);
    logic [31:0] cur, prv;
    cur = hist[i][syncOf(i)-1];
    prv = hist[i][syncOf(i)];
    case (i)
      0:       return cur & ~prv;
      1:       return ~cur & prv & wmaskOf(i);
      default: return cur ^ prv;
    endcase
  endfunction

  function automatic logic wrHit(logic [2:0] a);
    return chipselect && !write_n && (address == a);
  endfunction

  function automatic logic [31:0] readModel(int i, logic [2:0] a);
    case (a)
      3'd0:    return (mDir[i] & mData[i]) | (~mDir[i] & hist[i][syncOf(i)-1]);
      3'd1:    return mDir[i];
      3'd2:    return mMask[i];
      3'd3:    return mCap[i];
      3'd6:    return mData[i];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        mData[i] <= rstOutOf(i);
        mDir[i]  <= rstDirOf(i);
        mMask[i] <= 32'h0;
        mCap[i]  <= 32'h0;
        mIrq[i]  <= 1'b0;
        for (int k = 0; k < 4; k++) hist[i][k] <= 32'h0;
      end else begin
        mIrq[i] <= |(mCap[i] & mMask[i]);
        mCap[i] <= eventsOf(i) | (mCap[i] & ~(wrHit(3'd3) ? (writedata & wmaskOf(i)) : 32'h0));
        if (wrHit(3'd0))      mData[i] <= writedata & wmaskOf(i);
        else if (wrHit(3'd4)) mData[i] <= mData[i] | (writedata & wmaskOf(i));
        else if (wrHit(3'd5)) mData[i] <= mData[i] & ~(writedata & wmaskOf(i));
        if (wrHit(3'd1)) mDir[i]  <= writedata & wmaskOf(i);
        if (wrHit(3'd2)) mMask[i] <= writedata & wmaskOf(i);
        hist[i][0] <= pins & wmaskOf(i);
        for (int k = 1; k < 4; k++) hist[i][k] <= hist[i][k-1];
      end
    end
  end

  task automatic checkOutput(input string name, input int inst, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d cycle %0d got %h expected %h", name, inst, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (e.chkRd) checkOutput("readdata", i, rdP[i], e.rd[i*32 +: 32]);
        checkOutput("out_port", i, outP[i], e.out[i*32 +: 32]);
        checkOutput("oe_port", i, oeP[i], e.oe[i*32 +: 32]);
        checkOutput("irq", i, {31'h0, irqP[i]}, {31'h0, e.irq[i]});
      end
    end
  end

  // Drives one bus cycle, then records what every instance must show in it.
  task automatic applyStimulus(input logic rstN, input logic cs, input logic wn,
                               input logic [2:0] a, input logic [31:0] wd,
                               input logic [31:0] p);
    expT e;
    reset_n    = rstN;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    pins       = p;
    #1;
    e.chkRd = cs & wn;
    for (int i = 0; i < 3; i++) begin
      e.rd[i*32 +: 32]  = readModel(i, a);
      e.out[i*32 +: 32] = mData[i];
      e.oe[i*32 +: 32]  = mDir[i];
      e.irq[i]          = mIrq[i];
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, 1'b0, a, d, pins);
  endtask

  task automatic readReg(input logic [2:0] a);
    applyStimulus(1'b1, 1'b1, 1'b1, a, 32'h0, pins);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, pins);
  endtask

  task automatic setPins(input logic [31:0] p);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, p);
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
    pins       = 32'h0;
    @(posedge clk);
    #1;
    $display("[TB] reset values");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 32'h0, 32'h0);
    idleCycles(2);
    readReg(3'd0);
    readReg(3'd3);
    readReg(3'd1);

    $display("[TB] set/clear");
    writeReg(3'd0, 32'h0000_00A0);
    writeReg(3'd4, 32'h0000_000F);
    readReg(3'd6);
    writeReg(3'd5, 32'h0000_0081);
    readReg(3'd6);
    readReg(3'd4);
    readReg(3'd5);

    $display("[TB] mixed direction read");
    writeReg(3'd1, 32'h0000_000F);
    writeReg(3'd0, 32'h0000_005A);
    setPins(32'h0000_00C3);
    idleCycles(3);
    readReg(3'd0);

    $display("[TB] edge capture and irq");
    writeReg(3'd1, 32'h0);
    writeReg(3'd2, 32'h0000_0001);
    setPins(32'h0);
    idleCycles(5);
    writeReg(3'd3, 32'hFFFF_FFFF);
    idleCycles(2);
    setPins(32'h0000_0001);
    idleCycles(5);
    readReg(3'd3);
    writeReg(3'd3, 32'h0000_0001);
    idleCycles(3);
    readReg(3'd3);

    $display("[TB] event against same-cycle clear");
    setPins(32'h0000_0005);
    idleCycles(1);
    writeReg(3'd3, 32'h0000_0004);
    readReg(3'd3);
    idleCycles(3);

    $display("[TB] falling then rising on bit 2");
    writeReg(3'd3, 32'hFFFF_FFFF);
    setPins(32'h0000_0001);
    idleCycles(5);
    readReg(3'd3);
    setPins(32'h0000_0005);
    idleCycles(5);
    readReg(3'd3);

    $display("[TB] reset during operation");
    writeReg(3'd2, 32'hFFFF_FFFF);
    setPins(32'h0);
    idleCycles(4);
    writeReg(3'd3, 32'hFFFF_FFFF);
    setPins(32'hFFFF_FFFF);
    idleCycles(5);
    readReg(3'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 32'h0, pins);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h0, pins);
    idleCycles(5);
    readReg(3'd3);

    $display("[TB] ignored writes");
    writeReg(3'd7, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0055, pins);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd1, 32'hFFFF_FFFF, pins);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 32'h0, pins);
    readReg(3'd0);
    readReg(3'd1);
    readReg(3'd2);
    readReg(3'd7);
    writeReg(3'd6, 32'h0000_0012);
    readReg(3'd6);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      logic rstN;
      logic [31:0] p;
      rstN = ($urandom_range(0, 79) != 0);
      p    = ($urandom_range(0, 2) == 0) ? $urandom() : pins;
      applyStimulus(rstN, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), $urandom(), p);
    end
    idleCycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_gpio_pio.md
Name: avalon_gpio_pio

Overview:
Parametrised GPIO peripheral on the HPS-to-FPGA lightweight Avalon-MM bus, generalising the fixed 4-bit LED output PIO.
- Provides WIDTH bidirectional pins with a per-bit direction register.
- Supports atomic bit-set and bit-clear writes.
- Synchronises inputs and captures edges into a sticky register.
- Drives a level interrupt through a mask.
- Used for LEDs, keys, switches and CNN-accelerator status lines.

Parameters:
WIDTH, 8, number of GPIO bits (1..32)
RESET_OUT, 0, reset value of the output data register (WIDTH bits)
RESET_DIR, 0, reset value of the direction register (1 = output)
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge
SYNC_STAGES, 2, input synchroniser depth (2..3)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  Avalon word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data, combinational (read latency 0)
in_port  input  WIDTH  pad inputs, asynchronous to clk
out_port  output  WIDTH  pad output data
oe_port  output  WIDTH  per-bit output enable (= direction register)
irq  output  1  level interrupt, active-high

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock clk. On reset:
  - data_out = RESET_OUT, dir = RESET_DIR.
  - irqmask = 0, edgecap = 0.
  - Synchroniser stages and the previous-sample register = 0.
  - irq = 0, out_port = RESET_OUT, oe_port = RESET_DIR.
- Register map (word offsets). A write is chipselect & ~write_n; it takes effect at the next clk edge. Only writedata[WIDTH-1:0] is used.
  - 0 DATA: read = (dir & data_out) | (~dir & in_sync). Write loads data_out.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read = edgecap. Write-1-to-clear per bit.
  - 4 OUTSET: write data_out |= wd. Reads 0.
  - 5 OUTCLR: write data_out &= ~wd. Reads 0.
  - 6 OUTRB: read = data_out. Writes ignored.
  - 7: reserved. Reads 0, writes ignored.
- Read data: bits above WIDTH always 0. Reads have no side effects.
- Input path:
  - in_port passes through SYNC_STAGES flops to give in_sync.
  - in_prev <= in_sync every cycle.
  - Edge event per bit:
    - rising: in_sync & ~in_prev
    - falling: ~in_sync & in_prev
    - any: in_sync ^ in_prev
  - Latency pin to edgecap bit set = SYNC_STAGES+1 clk edges after the pin change is sampled.
- Edge capture:
  - edgecap[i] <= event[i] | (edgecap[i] & ~clr[i]).
  - A new event and a write-1-clear on the same bit in the same cycle: the event wins and the bit stays 1.
  - Events are captured regardless of dir and irqmask.
- Interrupt: irq is registered, irq <= |(edgecap & irqmask). It asserts one cycle after edgecap/irqmask change and deasserts one cycle after the last contributing bit is cleared or masked.
- Pin outputs: out_port = data_out and oe_port = dir, both combinational from registers.
- Reset during operation: all state returns to reset values immediately. A pending edge is lost. No spurious edge after reset release, because in_prev and in_sync both start at 0. A pin already high at release does produce one rising event once it propagates; this is accepted and documented.
- Assertions:
  - Non-chipselect cycles change no register.
  - For WIDTH=32 no truncation occurs.

Decomposition:
- Package gpio_pio_pkg:
  - Register offset constants: ADDR_DATA, ADDR_DIR, ADDR_IRQMASK, ADDR_EDGECAP, ADDR_OUTSET, ADDR_OUTCLR, ADDR_OUTRB.
  - EDGE_RISE / EDGE_FALL / EDGE_ANY encodings.
- One sub-module, gpio_sync_edge (params WIDTH, SYNC_STAGES, EDGE_TYPE): synchroniser, in_prev and event generation. Outputs in_sync and event.
- The top level holds the register file, edge capture, irq and read mux.

Test Plan:
- Reset with RESET_OUT=8'hA5, RESET_DIR=8'hFF -> out_port=A5, oe_port=FF, irq=0; read offset 0 = A5, offset 3 = 0.
- Write OUTSET 8'h0F then OUTCLR 8'h81 with data_out=A0 -> data_out AF then 2E; OUTRB reads 2E; reads of 4/5 return 0.
- dir=0x0F, in_port=0xC3, data_out=0x5A -> DATA reads 0xCA after SYNC_STAGES+1 cycles.
- EDGE_TYPE=0, irqmask=0x01, in_port[0] 0->1 -> edgecap=0x01 after SYNC_STAGES+1 cycles, irq high the next cycle. Write 0x01 to EDGECAP -> irq low one cycle after the clear.
- Rising edge on bit 2 arriving in the same cycle as a write-1-clear of bit 2 -> edgecap[2] remains 1; a falling pulse with EDGE_TYPE=0 -> no capture; EDGE_TYPE=2 -> both edges captured.
- Assert reset_n mid-operation with edgecap=0xFF, irq=1 -> all registers at reset values within the same cycle, irq=0; writes to offset 7 and writes with chipselect=0 change nothing.
